// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle for logic_op_arbiter: two valid/ready requesters and one tagged response channel.
// master = requester/consumer side, slave = arbiter side.
interface logic_op_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// Two-requester arbiter in front of one shared bitwise logic unit; IDLE -> EXEC -> RESP per op.
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module logic_op_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input logic               clk,
    input logic               rst_n,
    logic_op_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             grant0, grant1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    logic             rr_last_q, rr_last_d;
`endif

    function automatic logic [WIDTH-1:0] logic_fn(input logic [OPW-1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        unique case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = ~(a & b);
            3'b011:  r = ~(a | b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Grants exist only in IDLE, which is what masks both requesters while busy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = rr_last_q;
                grant1 = !rr_last_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        data_d    = data_q;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
        rr_last_d = rr_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_d    = grant1 ? bus.req1_op : bus.req0_op;
                    a_d     = grant1 ? bus.req1_a  : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b  : bus.req0_b;
                    id_d    = grant1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
                    rr_last_d = grant1;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = logic_fn(op_q, a_q, b_q);
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so it reads 0 for the whole reset interval, not just after the next edge.
    always_comb begin
        bus.req0_ready = rst_n && grant0;
        bus.req1_ready = rst_n && grant1;
        bus.rsp_valid  = (state_q == RESP);
        bus.busy       = (state_q != IDLE);
        bus.rsp_data   = data_q;
        bus.rsp_id     = id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and result registers are reset too, so rsp_data/rsp_id read 0 out of reset.
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            data_q    <= '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            data_q    <= data_d;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: transaction-level reference model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_logic_op_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic_op_arbiter_if #(.WIDTH(8), .OPW(3)) bus ();

    logic_op_arbiter #(.WIDTH(8), .OPW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } rsp_t;

    rsp_t rsp_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Reference model: one op in flight, counted in cycles since grant (0 = free).
    int         m_age = 0;
    logic       m_last_was1 = 1'b1;
    logic       m_id = 1'b0;
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_data = 8'h00;

    always @(negedge clk) begin
        logic w0, w1;
        if (!rst_n) begin
            m_age = 0;
            m_last_was1 = 1'b1;
            m_id = 1'b0;
            m_data = 8'h00;
        end else begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
            w0 = (m_age == 0) && bus.req0_valid;
            w1 = (m_age == 0) && bus.req1_valid && !bus.req0_valid;
`else
            w0 = (m_age == 0) && bus.req0_valid && (!bus.req1_valid || m_last_was1);
            w1 = (m_age == 0) && bus.req1_valid && (!bus.req0_valid || !m_last_was1);
`endif
            check("req0_ready", bus.req0_ready, w0);
            check("req1_ready", bus.req1_ready, w1);
            check("busy", bus.busy, m_age != 0);
            check("rsp_valid", bus.rsp_valid, m_age == 2);
            check("rsp_data", bus.rsp_data, m_data);
            if (m_age == 2) check("rsp_id", bus.rsp_id, m_id);
            if (bus.rsp_valid && bus.rsp_ready) rsp_log.push_back('{id: bus.rsp_id, data: bus.rsp_data});

            if (m_age == 0 && (w0 || w1)) begin
                m_id = w1;
                m_last_was1 = w1;
                m_res = w1 ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                           : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
                m_age = 1;
            end else if (m_age == 1) begin
                m_data = m_res;
                m_age = 2;
            end else if (m_age == 2 && bus.rsp_ready) begin
                m_age = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op on a requester and holds it until accepted; returns the cycle of the ready.
    task automatic issue(input logic which, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int ready_cyc);
        bit got = 0;
        ready_cyc = -1;
        if (which) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((which && bus.req1_ready) || (!which && bus.req0_ready)) begin
                got = 1;
                ready_cyc = cyc;
            end
        end
        if (!got) check("issue_timeout", 0, 1);
        step();
        if (which) bus.req1_valid = 1'b0;
        else       bus.req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int valid_cyc);
        bit got = 0;
        valid_cyc = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1;
                valid_cyc = cyc;
            end
        end
        if (!got) check("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!bus.busy) got = 1;
        end
        if (!got) check("idle_timeout", 0, 1);
        step();
    endtask

    initial begin
        int rc, vc, grants;
        logic [7:0] sweep_exp [8];
        sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'h55};

        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        step();

        // Single NAND op, latency and one-cycle response
        rsp_log.delete();
        issue(1'b0, 3'b010, 8'hFF, 8'h4A, rc);
        wait_rsp(vc);
        check("nand_latency", vc - rc, 2);
        wait_idle();
        check("nand_count", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) begin
            check("nand_data", rsp_log[0].data, 8'hB5);
            check("nand_id", rsp_log[0].id, 0);
        end

        // Opcode sweep
        rsp_log.delete();
        for (int op = 0; op < 8; op++) begin
            issue(1'b0, 3'(op), 8'h55, 8'hAA, rc);
            wait_idle();
        end
        check("sweep_count", rsp_log.size(), 8);
        for (int k = 0; k < 8 && k < rsp_log.size(); k++)
            check($sformatf("sweep_op%0d", k), rsp_log[k].data, sweep_exp[k]);

        // Operand change after grant: latched value must be used
        rsp_log.delete();
        issue(1'b0, 3'b000, 8'hF0, 8'h3C, rc);
        bus.req0_a = 8'h0F;
        bus.req0_b = 8'hFF;
        wait_idle();
        check("latch_count", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) check("latch_data", rsp_log[0].data, 8'h30);

        // Backpressure: response held for 5 cycles while req0 waits
        rsp_log.delete();
        bus.rsp_ready = 1'b0;
        issue(1'b1, 3'b100, 8'h3C, 8'h0F, rc);
        bus.req0_valid = 1'b1; bus.req0_op = 3'b001; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
        wait_rsp(vc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data", bus.rsp_data, 8'h33);
            check("bp_id", bus.rsp_id, 1);
            check("bp_ready0", bus.req0_ready, 0);
        end
        step();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 3'b001, 8'h01, 8'h02, rc);
        wait_idle();
        check("bp_count", rsp_log.size(), 2);
        if (rsp_log.size() >= 2) begin
            check("bp_first", {rsp_log[0].id, rsp_log[0].data}, {1'b1, 8'h33});
            check("bp_second", {rsp_log[1].id, rsp_log[1].data}, {1'b0, 8'h03});
        end

        // Async reset while a response is pending
        bus.rsp_ready = 1'b0;
        issue(1'b1, 3'b000, 8'hFF, 8'hC3, rc);
        wait_rsp(vc);
        #2;
        bus.req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_ready0", bus.req0_ready, 0);
        check("arst_ready1", bus.req1_ready, 0);
        check("arst_rsp_data", bus.rsp_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", bus.rsp_valid, 0);
        step();

        // Contention: both valid continuously for four grants
        rsp_log.delete();
        bus.req0_valid = 1; bus.req0_op = 3'b100; bus.req0_a = 8'h0F; bus.req0_b = 8'hFF;
        bus.req1_valid = 1; bus.req1_op = 3'b000; bus.req1_a = 8'h81; bus.req1_b = 8'hFF;
        grants = 0;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) grants++;
        end
        check("cont_grants", grants, 4);
        step();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        wait_idle();
        check("cont_count", rsp_log.size(), 4);
        for (int k = 0; k < 4 && k < rsp_log.size(); k++) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
            check($sformatf("cont_%0d", k), {rsp_log[k].id, rsp_log[k].data}, {1'b0, 8'hF0});
`else
            check($sformatf("cont_%0d", k), {rsp_log[k].id, rsp_log[k].data},
                  (k % 2 == 0) ? {1'b0, 8'hF0} : {1'b1, 8'h81});
`endif
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
